// File: rtl/capp_pkg.sv
// Purpose  : shared opcodes, FSM state encoding and default geometry for the CAPP word array.
// Latency  : n/a (declarations only).
// Backpres.: n/a.
// Contents : capp_op_e (3-bit opcode), capp_state_e (IDLE/EXEC/RESP), CAPP_W_DEF / CAPP_N_DEF.
package capp_pkg;

  localparam int CAPP_W_DEF = 32;
  localparam int CAPP_N_DEF = 64;

  typedef enum logic [2:0] {
    OP_NOP      = 3'd0,
    OP_WRITE    = 3'd1,
    OP_SEARCH   = 3'd2,
    OP_MWRITE   = 3'd3,
    OP_SELFIRST = 3'd4,
    OP_READ     = 3'd5,
    OP_CLEAR    = 3'd6,
    OP_RSVD     = 3'd7
  } capp_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } capp_state_e;

endpackage

// File: rtl/capp_first_resolve.sv
// Purpose  : lowest-set-bit priority resolver over an N-bit tag vector.
// Latency  : combinational.
// Backpres.: none (pure function of vec_i).
// Ports    : vec_i (N) in; some_o (any bit set), first_o (lowest set index, 0 if none),
//            onehot_o (vec_i with only its lowest set bit kept) out.
module capp_first_resolve #(
  parameter int  N  = 64,
  localparam int AW = $clog2(N)
) (
  input  logic [N-1:0]  vec_i,
  output logic          some_o,
  output logic [AW-1:0] first_o,
  output logic [N-1:0]  onehot_o
);

  assign some_o   = |vec_i;
  // Two's-complement trick: x & -x isolates the lowest set bit.
  assign onehot_o = vec_i & (~vec_i + N'(1));

  // Scan downwards so the lowest set index is the last one written.
  always_comb begin
    first_o = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec_i[i]) first_o = AW'(i);
    end
  end

endmodule

// File: rtl/capp_search_array.sv
// Purpose  : N x W content-addressable word array with per-word tags; one command in flight.
// Latency  : accept -> resp_valid 2 cycles (IDLE->EXEC->RESP); at most one command per 3 cycles.
// Backpres.: cmd_ready only in IDLE; RESP holds resp_* stable until resp_ready.
// Ports    : CLK, RST_N (async, active low); cmd_valid/ready/op/addr/data/mask/chain command in;
//            resp_valid/ready/some/first/data response; tag_o live tags;
//            tag_count popcount of tags, present only when CAPP_COUNT_EN is defined.
module capp_search_array
  import capp_pkg::*;
#(
  parameter int  W  = CAPP_W_DEF,
  parameter int  N  = CAPP_N_DEF,
  localparam int AW = $clog2(N)
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [2:0]    cmd_op,
  input  logic [AW-1:0] cmd_addr,
  input  logic [W-1:0]  cmd_data,
  input  logic [W-1:0]  cmd_mask,
  input  logic          cmd_chain,
  output logic          resp_valid,
  input  logic          resp_ready,
  output logic          resp_some,
  output logic [AW-1:0] resp_first,
  output logic [W-1:0]  resp_data,
  output logic [N-1:0]  tag_o
`ifdef CAPP_COUNT_EN
  ,
  output logic [AW:0]   tag_count
`endif
);

  localparam logic [1:0] S_IDLE = ST_IDLE;
  localparam logic [1:0] S_EXEC = ST_EXEC;
  localparam logic [1:0] S_RESP = ST_RESP;

  logic [1:0]    state_q, state_d;
  capp_op_e      op_q;
  logic [AW-1:0] addr_q;
  logic [W-1:0]  data_q, mask_q;
  logic          chain_q;

  logic [W-1:0]  mem_q [N];
  logic [W-1:0]  mem_d [N];
  logic [N-1:0]  tag_q, tag_d;
  logic [N-1:0]  match;

  logic          first_some;
  logic [AW-1:0] first_idx;
  logic [N-1:0]  first_oh;
  logic [W-1:0]  rd_word;

  // Unmasked bits always compare equal, so mask=0 matches every word.
  for (genvar gi = 0; gi < N; gi++) begin : g_cmp
    assign match[gi] = &(~(mem_q[gi] ^ data_q) | ~mask_q);
  end

  // One resolver on the registered tags serves both uses: in EXEC it sees the
  // pre-command tags (SELFIRST), in RESP it sees the post-command tags, which
  // cannot change again until the response has been consumed.
  capp_first_resolve #(.N(N)) u_first (
    .vec_i   (tag_q),
    .some_o  (first_some),
    .first_o (first_idx),
    .onehot_o(first_oh)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (cmd_valid)  state_d = S_EXEC;
      S_EXEC:                  state_d = S_RESP;
      S_RESP:  if (resp_ready) state_d = S_IDLE;
      default:                 state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mem_d = mem_q;
    tag_d = tag_q;
    if (state_q == S_EXEC) begin
      case (op_q)
        OP_WRITE: begin
          // N need not be a power of two; out-of-range indices are dropped.
          if ({1'b0, addr_q} < (AW+1)'(N))
            mem_d[addr_q] = (mem_q[addr_q] & ~mask_q) | (data_q & mask_q);
        end
        OP_SEARCH:   tag_d = chain_q ? (match & tag_q) : match;
        OP_MWRITE: begin
          for (int i = 0; i < N; i++) begin
            if (tag_q[i]) mem_d[i] = (mem_q[i] & ~mask_q) | (data_q & mask_q);
          end
        end
        OP_SELFIRST: tag_d = first_oh;
        OP_CLEAR:    tag_d = '0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      op_q    <= OP_NOP;
      addr_q  <= '0;
      data_q  <= '0;
      mask_q  <= '0;
      chain_q <= 1'b0;
      tag_q   <= '0;
      for (int i = 0; i < N; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && cmd_valid) begin
        op_q    <= capp_op_e'(cmd_op);
        addr_q  <= cmd_addr;
        data_q  <= cmd_data;
        mask_q  <= cmd_mask;
        chain_q <= cmd_chain;
      end
      tag_q <= tag_d;
      mem_q <= mem_d;
    end
  end

  // AND-OR mux on the one-hot gives 0 automatically when no tag is set.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < N; i++) rd_word = rd_word | (mem_q[i] & {W{first_oh[i]}});
  end

  assign cmd_ready  = (state_q == S_IDLE);
  assign resp_valid = (state_q == S_RESP);
  assign resp_some  = resp_valid & first_some;
  assign resp_first = resp_valid ? first_idx : '0;
  assign resp_data  = (resp_valid && op_q == OP_READ) ? rd_word : '0;
  assign tag_o      = tag_q;

`ifdef CAPP_COUNT_EN
  logic [AW:0] count_q, count_d;

  always_comb begin
    count_d = '0;
    for (int i = 0; i < N; i++) count_d = count_d + (AW+1)'(tag_d[i]);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) count_q <= '0;
    else        count_q <= count_d;
  end

  assign tag_count = count_q;
`endif

endmodule

// File: tb/tb_capp_search_array.sv
// Purpose  : self-checking bench for capp_search_array at W=8, N=16.
// Latency  : n/a.
// Backpres.: drives resp_ready with fixed and random hold-off.
module tb_capp_search_array;

  localparam int W  = 8;
  localparam int N  = 16;
  localparam int AW = 4;

  localparam logic [2:0] C_NOP = 3'd0, C_WR = 3'd1, C_SR = 3'd2, C_MW = 3'd3;
  localparam logic [2:0] C_SF  = 3'd4, C_RD = 3'd5, C_CLR = 3'd6, C_RSV = 3'd7;

  logic          CLK = 1'b0;
  logic          RST_N;
  logic          cmd_valid, cmd_ready, cmd_chain;
  logic [2:0]    cmd_op;
  logic [AW-1:0] cmd_addr;
  logic [W-1:0]  cmd_data, cmd_mask;
  logic          resp_valid, resp_ready, resp_some;
  logic [AW-1:0] resp_first;
  logic [W-1:0]  resp_data;
  logic [N-1:0]  tag_o;
`ifdef CAPP_COUNT_EN
  logic [AW:0]   tag_count;
`endif

  capp_search_array #(.W(W), .N(N)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_mask(cmd_mask), .cmd_chain(cmd_chain),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_some(resp_some),
    .resp_first(resp_first), .resp_data(resp_data), .tag_o(tag_o)
`ifdef CAPP_COUNT_EN
    , .tag_count(tag_count)
`endif
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // ---------------- reference model (behavioural) ----------------
  logic [W-1:0] m_mem [N];
  logic [N-1:0] m_tag;

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_mem[i] = '0;
    m_tag = '0;
  endtask

  function automatic int lowest(input logic [N-1:0] t);
    for (int i = 0; i < N; i++) if (t[i]) return i;
    return 0;
  endfunction

  task automatic model_cmd(input logic [2:0] op, input logic [AW-1:0] addr,
                           input logic [W-1:0] data, input logic [W-1:0] mask, input logic chain,
                           output logic [N-1:0] etag, output logic esome,
                           output logic [AW-1:0] efirst, output logic [W-1:0] edata);
    case (op)
      C_WR: m_mem[addr] = (m_mem[addr] & ~mask) | (data & mask);
      C_SR: for (int i = 0; i < N; i++)
              m_tag[i] = (((m_mem[i] ^ data) & mask) == 0) && (!chain || m_tag[i]);
      C_MW: for (int i = 0; i < N; i++)
              if (m_tag[i]) m_mem[i] = (m_mem[i] & ~mask) | (data & mask);
      C_SF: if (m_tag != 0) m_tag = N'(1) << lowest(m_tag);
      C_CLR: m_tag = '0;
      default: ;
    endcase
    etag   = m_tag;
    esome  = (m_tag != 0);
    efirst = AW'(lowest(m_tag));
    edata  = (op == C_RD && esome) ? m_mem[lowest(m_tag)] : '0;
  endtask

  // ---------------- command driver ----------------
  int           r_lat;
  logic [N-1:0] r_tag;
  logic         r_some;
  logic [AW-1:0] r_first;
  logic [W-1:0] r_data;

  task automatic wait_resp(output int cyc);
    cyc = 1;
    while (!resp_valid && cyc < 20) begin
      @(posedge CLK); #1;
      cyc++;
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [AW-1:0] addr,
                       input logic [W-1:0] data, input logic [W-1:0] mask, input logic chain);
    int cyc;
    cyc = 0;
    while (!cmd_ready && cyc < 20) begin
      @(posedge CLK); #1;
      cyc++;
    end
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr;
    cmd_data = data; cmd_mask = mask; cmd_chain = chain;
    @(posedge CLK); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic run_cmd(input logic [2:0] op, input logic [AW-1:0] addr,
                         input logic [W-1:0] data, input logic [W-1:0] mask,
                         input logic chain, input int hold);
    issue(op, addr, data, mask, chain);
    wait_resp(r_lat);
    r_tag = tag_o; r_some = resp_some; r_first = resp_first; r_data = resp_data;
    repeat (hold) begin
      @(posedge CLK); #1;
    end
    resp_ready = 1'b1;
    @(posedge CLK); #1;
    resp_ready = 1'b0;
  endtask

  task automatic check_resp(input string name, input logic [N-1:0] etag, input logic esome,
                            input logic [AW-1:0] efirst, input logic [W-1:0] edata);
    check({name, ".latency"}, r_lat, 2);
    check({name, ".tag"},     r_tag, etag);
    check({name, ".some"},    r_some, esome);
    check({name, ".first"},   r_first, efirst);
    check({name, ".data"},    r_data, edata);
`ifdef CAPP_COUNT_EN
    check({name, ".count"},   tag_count, $countones(etag));
`endif
  endtask

  task automatic do_reset();
    #2 RST_N = 1'b0;
    #10 RST_N = 1'b1;
    @(posedge CLK); #1;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [2:0]    op;
    logic [AW-1:0] addr;
    logic [W-1:0]  data;
    logic [W-1:0]  mask;
    logic          chain;
    logic [N-1:0]  tag;
    logic          some;
    logic [AW-1:0] first;
    logic [W-1:0]  rdata;
  } vec_t;

  function automatic vec_t mk(input logic [2:0] op, input logic [AW-1:0] addr,
                              input logic [W-1:0] data, input logic [W-1:0] mask,
                              input logic chain, input logic [N-1:0] tag, input logic some,
                              input logic [AW-1:0] first, input logic [W-1:0] rdata);
    vec_t v;
    v.op = op; v.addr = addr; v.data = data; v.mask = mask; v.chain = chain;
    v.tag = tag; v.some = some; v.first = first; v.rdata = rdata;
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    int cyc;
    logic [N-1:0]  etag;
    logic          esome;
    logic [AW-1:0] efirst;
    logic [W-1:0]  edata;
    logic [2:0]    rop;
    logic [W-1:0]  rdat, rmsk;
    logic [AW-1:0] radr;

    RST_N = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0;
    cmd_data = '0; cmd_mask = '0; cmd_chain = 1'b0; resp_ready = 1'b0;

    //            op     adr  data   mask   ch  tag       some first rdata
    tbl.push_back(mk(C_WR,  3, 8'hA5, 8'hFF, 0, 16'h0000, 0, 0, 8'h00));
    tbl.push_back(mk(C_SR,  0, 8'hA5, 8'hFF, 0, 16'h0008, 1, 3, 8'h00));
    tbl.push_back(mk(C_WR,  2, 8'h3C, 8'hFF, 0, 16'h0008, 1, 3, 8'h00));
    tbl.push_back(mk(C_WR,  5, 8'h3C, 8'hFF, 0, 16'h0008, 1, 3, 8'h00));
    tbl.push_back(mk(C_WR,  9, 8'h3C, 8'hFF, 0, 16'h0008, 1, 3, 8'h00));
    tbl.push_back(mk(C_SR,  0, 8'h0C, 8'h0F, 0, 16'h0224, 1, 2, 8'h00));
    tbl.push_back(mk(C_SF,  0, 8'h00, 8'h00, 0, 16'h0004, 1, 2, 8'h00));
    tbl.push_back(mk(C_RD,  0, 8'h00, 8'h00, 0, 16'h0004, 1, 2, 8'h3C));
    tbl.push_back(mk(C_SR,  0, 8'h5A, 8'h00, 0, 16'hFFFF, 1, 0, 8'h00));
    tbl.push_back(mk(C_CLR, 0, 8'h00, 8'h00, 0, 16'h0000, 0, 0, 8'h00));
    tbl.push_back(mk(C_RD,  0, 8'h00, 8'h00, 0, 16'h0000, 0, 0, 8'h00));
    tbl.push_back(mk(C_WR,  9, 8'h00, 8'hFF, 0, 16'h0000, 0, 0, 8'h00));
    tbl.push_back(mk(C_SR,  0, 8'h3C, 8'hFF, 0, 16'h0024, 1, 2, 8'h00));
    tbl.push_back(mk(C_WR,  9, 8'h3C, 8'hFF, 0, 16'h0024, 1, 2, 8'h00));
    tbl.push_back(mk(C_MW,  0, 8'hF0, 8'hF0, 0, 16'h0024, 1, 2, 8'h00));
    tbl.push_back(mk(C_SR,  0, 8'hFC, 8'hFF, 1, 16'h0024, 1, 2, 8'h00));
    tbl.push_back(mk(C_RD,  0, 8'h00, 8'h00, 0, 16'h0024, 1, 2, 8'hFC));
    tbl.push_back(mk(C_SR,  0, 8'h3C, 8'hFF, 0, 16'h0200, 1, 9, 8'h00));
    tbl.push_back(mk(C_RSV, 0, 8'h00, 8'h00, 0, 16'h0200, 1, 9, 8'h00));
    tbl.push_back(mk(C_NOP, 0, 8'h00, 8'h00, 0, 16'h0200, 1, 9, 8'h00));
    tbl.push_back(mk(C_WR,  9, 8'h00, 8'h0F, 0, 16'h0200, 1, 9, 8'h00));
    tbl.push_back(mk(C_SR,  0, 8'h30, 8'hFF, 0, 16'h0200, 1, 9, 8'h00));
    tbl.push_back(mk(C_CLR, 0, 8'h00, 8'h00, 0, 16'h0000, 0, 0, 8'h00));
    tbl.push_back(mk(C_MW,  0, 8'h55, 8'hFF, 0, 16'h0000, 0, 0, 8'h00));
    tbl.push_back(mk(C_SR,  0, 8'hFC, 8'hFF, 0, 16'h0024, 1, 2, 8'h00));
    tbl.push_back(mk(C_CLR, 0, 8'h00, 8'h00, 0, 16'h0000, 0, 0, 8'h00));
    tbl.push_back(mk(C_SR,  0, 8'h00, 8'h00, 1, 16'h0000, 0, 0, 8'h00));
    tbl.push_back(mk(C_SR,  0, 8'hA5, 8'hFF, 0, 16'h0008, 1, 3, 8'h00));
    tbl.push_back(mk(C_SF,  0, 8'h00, 8'h00, 0, 16'h0008, 1, 3, 8'h00));
    tbl.push_back(mk(C_CLR, 0, 8'h00, 8'h00, 0, 16'h0000, 0, 0, 8'h00));
    tbl.push_back(mk(C_SF,  0, 8'h00, 8'h00, 0, 16'h0000, 0, 0, 8'h00));

    // Reset values, sampled while reset is asserted.
    #12;
    check("rst.cmd_ready",  cmd_ready, 1);
    check("rst.resp_valid", resp_valid, 0);
    check("rst.resp_some",  resp_some, 0);
    check("rst.resp_first", resp_first, 0);
    check("rst.resp_data",  resp_data, 0);
    check("rst.tag",        tag_o, 0);
`ifdef CAPP_COUNT_EN
    check("rst.count",      tag_count, 0);
`endif
    #3 RST_N = 1'b1;
    @(posedge CLK); #1;

    foreach (tbl[k]) begin
      run_cmd(tbl[k].op, tbl[k].addr, tbl[k].data, tbl[k].mask, tbl[k].chain, k % 3);
      check_resp($sformatf("tbl[%0d]", k), tbl[k].tag, tbl[k].some, tbl[k].first, tbl[k].rdata);
    end

    // Backpressure: response held 5 cycles, a competing command must be ignored.
    run_cmd(C_SR, 0, 8'hFC, 8'hFF, 0, 0);
    check_resp("bp.setup", 16'h0024, 1, 2, 8'h00);
    issue(C_RD, 0, 8'h00, 8'h00, 0);
    wait_resp(cyc);
    check("bp.latency", cyc, 2);
    cmd_valid = 1'b1; cmd_op = C_CLR;
    for (int c = 0; c < 5; c++) begin
      check("bp.resp_valid", resp_valid, 1);
      check("bp.cmd_ready",  cmd_ready, 0);
      check("bp.resp_data",  resp_data, 8'hFC);
      check("bp.resp_first", resp_first, 2);
      check("bp.resp_some",  resp_some, 1);
      check("bp.tag",        tag_o, 16'h0024);
      @(posedge CLK); #1;
    end
    cmd_valid = 1'b0;
    resp_ready = 1'b1;
    @(posedge CLK); #1;
    resp_ready = 1'b0;
    check("bp.done_valid", resp_valid, 0);
    check("bp.done_ready", cmd_ready, 1);
    check("bp.tag_kept",   tag_o, 16'h0024);

    // Reset while a response is pending.
    issue(C_SR, 0, 8'h00, 8'h00, 0);
    wait_resp(cyc);
    check("mr.tag_before", tag_o, 16'hFFFF);
    #2 RST_N = 1'b0;
    #1;
    check("mr.resp_valid", resp_valid, 0);
    check("mr.cmd_ready",  cmd_ready, 1);
    check("mr.resp_some",  resp_some, 0);
    check("mr.resp_first", resp_first, 0);
    check("mr.tag",        tag_o, 0);
`ifdef CAPP_COUNT_EN
    check("mr.count",      tag_count, 0);
`endif
    #4 RST_N = 1'b1;
    @(posedge CLK); #1;
    run_cmd(C_SR, 0, 8'h00, 8'hFF, 0, 0);
    check_resp("mr.words_zero", 16'hFFFF, 1, 0, 8'h00);
    run_cmd(C_RD, 0, 8'h00, 8'h00, 0, 0);
    check_resp("mr.read0", 16'hFFFF, 1, 0, 8'h00);

    // Randomised commands against the reference model.
    do_reset();
    model_reset();
    for (int k = 0; k < 200; k++) begin
      rop  = 3'($urandom_range(0, 7));
      radr = AW'($urandom_range(0, N - 1));
      case ($urandom_range(0, 3))
        0:       rdat = m_mem[$urandom_range(0, N - 1)];
        1:       rdat = W'($urandom_range(0, 3) * 8'h11);
        default: rdat = W'($urandom);
      endcase
      case ($urandom_range(0, 3))
        0:       rmsk = 8'hFF;
        1:       rmsk = 8'h00;
        default: rmsk = W'($urandom);
      endcase
      run_cmd(rop, radr, rdat, rmsk, 1'($urandom_range(0, 1)), $urandom_range(0, 2));
      model_cmd(rop, radr, rdat, rmsk, cmd_chain, etag, esome, efirst, edata);
      check_resp($sformatf("rnd[%0d] op%0d", k, rop), etag, esome, efirst, edata);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
